// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state one-hot codes and
// control-word bit indices used by the sequencer, datapath and benches.
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // T-state bit positions within the one-hot ring
   localparam int T1 = 0;
   localparam int T2 = 1;
   localparam int T3 = 2;
   localparam int T4 = 3;
   localparam int T5 = 4;
   localparam int T6 = 5;

   localparam logic [5:0] T1_OH = 6'b000001;

   // Control-word bit indices; a set bit means "asserted",
   // independent of the pin polarity of the line it drives.
   localparam int CW_CP = 0;
   localparam int CW_EP = 1;
   localparam int CW_LM = 2;
   localparam int CW_CE = 3;
   localparam int CW_LI = 4;
   localparam int CW_EI = 5;
   localparam int CW_LA = 6;
   localparam int CW_EA = 7;
   localparam int CW_SU = 8;
   localparam int CW_EU = 9;
   localparam int CW_LB = 10;
   localparam int CW_LO = 11;
   localparam int CW_W  = 12;

   typedef logic [CW_W-1:0] cw_t;

   localparam cw_t CW_IDLE = '0;

   typedef enum logic {
      SEQ_RUN,
      SEQ_HALTED
   } seq_state_t;

   function automatic cw_t cw_bit(input int idx);
      cw_t w;
      w = CW_IDLE;
      w[idx] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/ring_counter_6.sv
// Six-state one-hot ring counter for the SAP-1 T-states.
// Ports: clk, rst (sync, high -> T1), en (advance), freeze (park at
// all-zero, used on halt), ring (one-hot state, bit0 = T1).
module ring_counter_6
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       freeze,
   output logic [5:0] ring
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ring <= T1_OH;
      end else if (freeze) begin
         ring <= 6'b000000;
      end else if (en) begin
         ring <= {ring[4:0], ring[5]};
      end
   end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: T-state ring plus opcode decoder driving the bus
// control lines. Ports: clk, rst (sync high), run, opcode (IR[7:4]);
// control outputs (_n active-low), halt, tstate (one-hot, bit0 = T1).
module sap_controller_sequencer
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       pc_inc,
   output logic       pc_oe_n,
   output logic       mar_ld_n,
   output logic       ram_oe_n,
   output logic       ir_ld_n,
   output logic       ir_oe_n,
   output logic       acc_ld_n,
   output logic       acc_oe_n,
   output logic       alu_sub,
   output logic       alu_oe_n,
   output logic       b_ld_n,
   output logic       out_ld_n,
   output logic       halt,
   output logic [5:0] tstate
);

   seq_state_t state_q;
   seq_state_t state_d;
   logic [5:0] ring;
   logic       ring_en;
   logic       ring_freeze;
   logic       halt_int;
   cw_t        cw;
   cw_t        cw_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEQ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      halt_int = 1'b0;
      cw       = CW_IDLE;
      unique case (state_q)
         SEQ_RUN: begin
            unique case (1'b1)
               ring[T1]: cw = cw_bit(CW_EP) | cw_bit(CW_LM);
               ring[T2]: cw = cw_bit(CW_CP);
               ring[T3]: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
               ring[T4]: begin
                  case (opcode)
                     OP_LDA, OP_ADD, OP_SUB:
                        cw = cw_bit(CW_EI) | cw_bit(CW_LM);
                     OP_OUT:
                        cw = cw_bit(CW_EA) | cw_bit(CW_LO);
                     OP_HLT: begin
                        halt_int = 1'b1;
                        if (run) begin
                           state_d = SEQ_HALTED;
                        end
                     end
                     default: cw = CW_IDLE;
                  endcase
               end
               ring[T5]: begin
                  case (opcode)
                     OP_LDA:
                        cw = cw_bit(CW_CE) | cw_bit(CW_LA);
                     OP_ADD, OP_SUB:
                        cw = cw_bit(CW_CE) | cw_bit(CW_LB);
                     default: cw = CW_IDLE;
                  endcase
               end
               ring[T6]: begin
                  case (opcode)
                     OP_ADD:
                        cw = cw_bit(CW_EU) | cw_bit(CW_LA);
                     OP_SUB:
                        cw = cw_bit(CW_EU) | cw_bit(CW_LA)
                           | cw_bit(CW_SU);
                     default: cw = CW_IDLE;
                  endcase
               end
               default: cw = CW_IDLE;
            endcase
         end
         SEQ_HALTED: begin
            halt_int = 1'b1;
         end
         default: begin
            state_d = SEQ_RUN;
         end
      endcase
   end

   assign ring_en     = run && (state_q == SEQ_RUN);
   assign ring_freeze = (state_q == SEQ_RUN)
                     && (state_d == SEQ_HALTED);

   ring_counter_6 u_ring (
      .clk    (clk),
      .rst    (rst),
      .en     (ring_en),
      .freeze (ring_freeze),
      .ring   (ring)
   );

   // Reset overrides the decode so the bus is quiet even before the
   // first reset edge has settled the state.
   assign cw_out = rst ? CW_IDLE : cw;
   assign halt   = !rst && halt_int;
   assign tstate = rst ? T1_OH : ring;

   assign pc_inc   =  cw_out[CW_CP];
   assign pc_oe_n  = !cw_out[CW_EP];
   assign mar_ld_n = !cw_out[CW_LM];
   assign ram_oe_n = !cw_out[CW_CE];
   assign ir_ld_n  = !cw_out[CW_LI];
   assign ir_oe_n  = !cw_out[CW_EI];
   assign acc_ld_n = !cw_out[CW_LA];
   assign acc_oe_n = !cw_out[CW_EA];
   assign alu_sub  =  cw_out[CW_SU];
   assign alu_oe_n = !cw_out[CW_EU];
   assign b_ld_n   = !cw_out[CW_LB];
   assign out_ld_n = !cw_out[CW_LO];

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Scoreboard bench for sap_controller_sequencer: directed instruction
// sequences followed by a randomized opcode/run/rst stream.
module tb_sap_controller_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] opcode = 4'b0000;
   logic       pc_inc, pc_oe_n, mar_ld_n, ram_oe_n, ir_ld_n, ir_oe_n;
   logic       acc_ld_n, acc_oe_n, alu_sub, alu_oe_n, b_ld_n, out_ld_n;
   logic       halt;
   logic [5:0] tstate;

   always #5 clk = ~clk;

   sap_controller_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .opcode   (opcode),
      .pc_inc   (pc_inc),
      .pc_oe_n  (pc_oe_n),
      .mar_ld_n (mar_ld_n),
      .ram_oe_n (ram_oe_n),
      .ir_ld_n  (ir_ld_n),
      .ir_oe_n  (ir_oe_n),
      .acc_ld_n (acc_ld_n),
      .acc_oe_n (acc_oe_n),
      .alu_sub  (alu_sub),
      .alu_oe_n (alu_oe_n),
      .b_ld_n   (b_ld_n),
      .out_ld_n (out_ld_n),
      .halt     (halt),
      .tstate   (tstate)
   );

   typedef struct packed {
      logic       pc_inc;
      logic       pc_oe_n;
      logic       mar_ld_n;
      logic       ram_oe_n;
      logic       ir_ld_n;
      logic       ir_oe_n;
      logic       acc_ld_n;
      logic       acc_oe_n;
      logic       alu_sub;
      logic       alu_oe_n;
      logic       b_ld_n;
      logic       out_ld_n;
      logic       halt;
      logic [5:0] tstate;
   } obs_t;

   typedef struct {
      obs_t  exp;
      string tag;
   } item_t;

   item_t q[$];
   int    checks = 0;
   int    failures = 0;

   // reference model: instruction step 0..5 and a halted flag
   int    m_step = 0;
   bit    m_halted = 1'b0;

   function automatic obs_t model_out(bit r, bit hlt, int step,
                                      logic [3:0] op);
      obs_t o;
      o = '{pc_inc:0, pc_oe_n:1, mar_ld_n:1, ram_oe_n:1, ir_ld_n:1,
            ir_oe_n:1, acc_ld_n:1, acc_oe_n:1, alu_sub:0, alu_oe_n:1,
            b_ld_n:1, out_ld_n:1, halt:0, tstate:6'b000001};
      if (r) return o;
      if (hlt) begin
         o.tstate = 6'b000000;
         o.halt = 1'b1;
         return o;
      end
      o.tstate = 6'(1 << step);
      if (step == 0) begin
         o.pc_oe_n = 0; o.mar_ld_n = 0;
      end else if (step == 1) begin
         o.pc_inc = 1;
      end else if (step == 2) begin
         o.ram_oe_n = 0; o.ir_ld_n = 0;
      end else if (step == 3) begin
         if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
            o.ir_oe_n = 0; o.mar_ld_n = 0;
         end else if (op == 4'hE) begin
            o.acc_oe_n = 0; o.out_ld_n = 0;
         end else if (op == 4'hF) begin
            o.halt = 1;
         end
      end else if (step == 4) begin
         if (op == 4'h0) begin
            o.ram_oe_n = 0; o.acc_ld_n = 0;
         end else if (op == 4'h1 || op == 4'h2) begin
            o.ram_oe_n = 0; o.b_ld_n = 0;
         end
      end else begin
         if (op == 4'h1 || op == 4'h2) begin
            o.alu_oe_n = 0; o.acc_ld_n = 0;
            o.alu_sub = (op == 4'h2);
         end
      end
      return o;
   endfunction

   task automatic cyc(input bit r, input bit rn, input logic [3:0] op,
                      input string tag);
      item_t it;
      @(negedge clk);
      rst = r;
      run = rn;
      opcode = op;
      #1;
      it.exp = model_out(r, m_halted, m_step, op);
      it.tag = tag;
      q.push_back(it);
      if (r) begin
         m_step = 0;
         m_halted = 1'b0;
      end else if (!m_halted && rn) begin
         if (m_step == 3 && op == 4'hF) m_halted = 1'b1;
         else m_step = (m_step + 1) % 6;
      end
   endtask

   task automatic instr(input logic [3:0] op, input string tag);
      for (int i = 0; i < 6; i++) cyc(0, 1, op, tag);
   endtask

   // monitor: outputs are valid every cycle, sampled mid-low-phase
   initial begin
      item_t it;
      obs_t  act;
      int    drivers;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            it = q.pop_front();
            act = '{pc_inc, pc_oe_n, mar_ld_n, ram_oe_n, ir_ld_n,
                    ir_oe_n, acc_ld_n, acc_oe_n, alu_sub, alu_oe_n,
                    b_ld_n, out_ld_n, halt, tstate};
            checks++;
            if (act !== it.exp) begin
               failures++;
               $display("FAIL %s: got %b expected %b (t=%0t)",
                        it.tag, act, it.exp, $time);
            end
            drivers = 0;
            if (pc_oe_n === 1'b0) drivers++;
            if (ram_oe_n === 1'b0) drivers++;
            if (ir_oe_n === 1'b0) drivers++;
            if (acc_oe_n === 1'b0) drivers++;
            if (alu_oe_n === 1'b0) drivers++;
            checks++;
            if (drivers > 1) begin
               failures++;
               $display("FAIL bus_single_driver: got %0d drivers required <=1",
                        drivers);
            end
         end
      end
   end

   initial begin
      logic [3:0] op;
      bit         r;
      bit         rn;
      int         sel;
      cyc(1, 0, 4'h0, "reset");
      cyc(1, 1, 4'h5, "reset_hold");
      cyc(0, 1, 4'h0, "lda_t1");
      for (int i = 0; i < 5; i++) cyc(0, 1, 4'h0, "lda");
      cyc(0, 1, 4'h0, "lda_wrap_t1");
      for (int i = 0; i < 5; i++) cyc(0, 1, 4'h1, "add");
      instr(4'h2, "sub");
      instr(4'hE, "out");
      instr(4'h7, "undef_nop");
      instr(4'h0, "lda_after_nop");
      // single-step freeze in T3
      cyc(0, 1, 4'h1, "step_t1");
      cyc(0, 1, 4'h1, "step_t2");
      for (int i = 0; i < 5; i++) cyc(0, 0, 4'h1, "frozen_t3");
      cyc(0, 1, 4'h1, "resume_t3");
      cyc(0, 1, 4'h1, "resume_t4");
      cyc(0, 0, 4'h1, "hold_t5");
      cyc(0, 1, 4'h1, "add_t5");
      cyc(0, 0, 4'h1, "frozen_add_t6");
      cyc(0, 1, 4'h1, "add_t6");
      // reset in T5 of ADD
      for (int i = 0; i < 4; i++) cyc(0, 1, 4'h1, "add_pre_rst");
      cyc(1, 1, 4'h1, "rst_in_t5");
      cyc(0, 1, 4'h1, "t1_after_rst");
      for (int i = 0; i < 5; i++) cyc(0, 1, 4'h1, "add_post_rst");
      // HLT with run toggling while halted
      for (int i = 0; i < 3; i++) cyc(0, 1, 4'hF, "hlt_fetch");
      cyc(0, 0, 4'hF, "hlt_t4_run_low");
      cyc(0, 1, 4'hF, "hlt_t4");
      for (int i = 0; i < 20; i++)
         cyc(0, 1'($urandom_range(0, 1)), 4'($urandom), "halted");
      cyc(1, 0, 4'hF, "rst_from_halt");
      cyc(0, 1, 4'h2, "t1_after_halt");
      // randomized stream
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 20) op = 4'h0;
         else if (sel < 40) op = 4'h1;
         else if (sel < 60) op = 4'h2;
         else if (sel < 75) op = 4'hE;
         else if (sel < 80) op = 4'hF;
         else op = 4'($urandom);
         rn = ($urandom_range(0, 99) < 80);
         r = ($urandom_range(0, 99) < 3);
         cyc(r, rn, op, "random");
      end
      @(negedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
